// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: registered grant FSM (IDLE/OWN0/OWN1) muxing one
// master at a time onto a single bridge port. Ties go to the master that did
// not own the bus last, and master 0 wins the first tie after reset.
// Optional build macro ARB_HOLD_LIMIT_EN: a locked owner is forced to rotate
// once it has held the bus for MAX_HOLD cycles while the other master waits.
module bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_lock,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m0_wen,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m0_wdata,
  input  logic [ADDR_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] m0_rdata,
  output logic [ADDR_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] Bus_addr,
  output logic              Bus_wen,
  output logic [ADDR_W-1:0] Bus_wdata,
  input  logic [ADDR_W-1:0] Bus_rdata
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("bus_arbiter: MAX_HOLD must be within 2..255");
  end

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;   // 0: master 0 owned last, 1: master 1 owned last
  logic   hold_expired;     // owner has used up its hold budget

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HoldMax  = 8'(MAX_HOLD);
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;

  // hold_q counts completed cycles of the current ownership, so the current
  // cycle is the MAX_HOLD-th one when hold_q has reached MAX_HOLD-1
  assign hold_expired = (hold_q >= HoldLast);

  // Hold counter next state: clear on any state change, count while owned, saturate
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q) begin
      hold_d = 8'd0;
    end else if (state_q != IDLE && hold_q != HoldMax) begin
      hold_d = hold_q + 8'd1;
    end
  end

  // Hold counter register
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  // State and last-owner registers
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic and last-owner tracking
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = last_q ? OWN0 : OWN1;
        else if (m0_req)      state_d = OWN0;
        else if (m1_req)      state_d = OWN1;
      end
      OWN0: begin
        // a dropping owner hands straight over when the other is waiting
        if (!m0_req)                                   state_d = m1_req ? OWN1 : IDLE;
        else if (m1_req && (!m0_lock || hold_expired)) state_d = OWN1;
      end
      OWN1: begin
        if (!m1_req)                                   state_d = m0_req ? OWN0 : IDLE;
        else if (m0_req && (!m1_lock || hold_expired)) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == OWN0 && state_q != OWN0) last_d = 1'b0;
    if (state_d == OWN1 && state_q != OWN1) last_d = 1'b1;
  end

  // Output mux: grants from registered state, bus driven by the owner only
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    Bus_addr  = '0;
    Bus_wen   = 1'b0;
    Bus_wdata = '0;
    case (state_q)
      OWN0: begin
        m0_gnt    = 1'b1;
        m0_ack    = m0_req;
        m0_rdata  = Bus_rdata;
        Bus_addr  = m0_addr;
        Bus_wdata = m0_wdata;
        Bus_wen   = m0_wen & m0_req;
      end
      OWN1: begin
        m1_gnt    = 1'b1;
        m1_ack    = m1_req;
        m1_rdata  = Bus_rdata;
        Bus_addr  = m1_addr;
        Bus_wdata = m1_wdata;
        Bus_wen   = m1_wen & m1_req;
      end
      default: ;
    endcase
  end

endmodule
